// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Timer width is derived from the watchdog limit by timer_width().
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic midx_t;

    localparam int          TIMEOUT_DEFAULT   = 255;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Enough bits to hold the limit itself; a disabled watchdog still gets one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating wait-cycle counter; expire flags the cycle whose count equals the limit.
// A limit of zero disables expiry entirely.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int           W     = timer_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0] MAX   = '1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of one memory slave port.
// The grant is held until the slave completes or the watchdog aborts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        err_timeout,
    output logic        err_master,
    output logic        busy
);

    // Handshake: a master holds valid until its one-cycle ready; the slave
    // sees a captured request with s_valid high until s_ready (or abort).

    state_t      state, state_next;
    midx_t       g, rr_last, pick;
    logic        any_req, done, abort, expire;
    logic [31:0] resp;

    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state == IDLE),
        .enable ((state == BUSY) && !s_ready),
        .expire (expire)
    );

    // Round-robin: a tie goes to the master that did not finish last.
    always_comb begin
        any_req = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
            pick = ~rr_last;
        end else begin
            pick = m1_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (done)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A slave ready in the expiry cycle wins over the abort.
    always_comb begin
        done     = (state == BUSY) && (s_ready || expire);
        abort    = (state == BUSY) && !s_ready && expire;
        resp     = s_ready ? s_rdata : ERR_RDATA;
        m0_ready = done && (g == 1'b0);
        m1_ready = done && (g == 1'b1);
        m0_rdata = m0_ready ? resp : 32'h0;
        m1_rdata = m1_ready ? resp : 32'h0;
        s_valid  = (state == BUSY);
        busy     = (state == BUSY);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            g           <= 1'b0;
            rr_last     <= 1'b1;
            s_instr     <= 1'b0;
            s_addr      <= 32'h0;
            s_wdata     <= 32'h0;
            s_wstrb     <= 4'h0;
            err_timeout <= 1'b0;
            err_master  <= 1'b0;
        end else begin
            err_timeout <= abort;
            if ((state == IDLE) && any_req) begin
                g       <= pick;
                s_instr <= pick ? m1_instr : m0_instr;
                s_addr  <= pick ? m1_addr  : m0_addr;
                s_wdata <= pick ? m1_wdata : m0_wdata;
                s_wstrb <= pick ? m1_wstrb : m0_wstrb;
            end
            if (done) begin
                rr_last <= g;
            end
            if (abort) begin
                err_master <= g;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the native CPU memory handshake (valid/instr/ready/addr/wdata/wstrb/rdata).
- Lets the CPU core and a second master (DMA or debug loader) share the single on-chip memory port.
- Round-robin grant, held until completion; captured request presented on the slave port.
- Watchdog aborts slave transactions that never complete.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without s_ready before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned to the master on an aborted transaction.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- m0_valid, m1_valid  in  1  request valid; held until the matching m*_ready.
- m0_instr, m1_instr  in  1  instruction-fetch flag.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 means read.
- m0_ready, m1_ready  out  1  transaction complete, one cycle.
- m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  slave request valid (registered).
- s_instr  out  1  captured instr flag.
- s_addr  out  32  captured address.
- s_wdata  out  32  captured write data.
- s_wstrb  out  4  captured write strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- err_timeout  out  1  one-cycle pulse after an abort (registered).
- err_master  out  1  index of the master whose transaction was aborted; holds until the next abort.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, s_valid=0, s_* captured fields=0.
  - timer=0, err_timeout=0, err_master=0.
  - rr_last=1, so m0 wins the first tie.
  - m*_ready=0, m*_rdata=0.
  - Reset mid-transaction drops s_valid immediately and does not complete the transaction.
- States: IDLE, BUSY.
- IDLE:
  - No m*_valid: stay in IDLE.
  - Exactly one m*_valid: grant it.
  - Both valid: grant the master != rr_last.
  - On grant, at the edge: capture that master's instr/addr/wdata/wstrb into the s_* registers, set g=granted index, s_valid<=1, timer<=0, state<=BUSY.
- BUSY:
  - s_* fields are stable and s_valid=1 every cycle.
  - The non-granted master's valid is ignored; its request waits.
  - Completion (s_ready=1), same cycle: m{g}_ready=1 and m{g}_rdata=s_rdata (combinational pass-through). Next edge: s_valid<=0, rr_last<=g, state<=IDLE.
  - Wait (s_ready=0): timer increments, saturating.
  - Abort: when TIMEOUT_CYCLES!=0, timer==TIMEOUT_CYCLES and s_ready=0.
    - Same cycle: m{g}_ready=1, m{g}_rdata=ERR_RDATA.
    - Next edge: s_valid<=0, err_timeout<=1, err_master<=g, rr_last<=g, state<=IDLE.
  - If s_ready=1 in the abort cycle, the transaction completes normally; no abort.
- Latency: request visible in cycle N -> s_valid from N+1. With a slave that answers one cycle after valid, m_ready is high in N+2. Back-to-back requests from one master are accepted in the cycle after its ready.
- Master contract:
  - Deassert valid, or present a new request, in the cycle after ready.
  - A valid seen in IDLE is always treated as a new request.
- Slave side:
  - s_ready while s_valid=0 is ignored, including a late ready after an abort.
  - Writes are forwarded unchanged; the arbiter never splits or merges strobes.
- Non-granted master: ready=0, rdata=0 at all times.
- Fairness: continuous requests from both masters alternate m0, m1, m0, ...; no master waits more than one other transaction.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, BUSY};
  - the master-index typedef (1 bit);
  - the ERR_RDATA default constant;
  - the timer width derived from TIMEOUT_CYCLES.
- One sub-module, mem_arb_watchdog: saturating counter with clear/enable inputs and an expire output compared against TIMEOUT_CYCLES.
- Round-robin pick stays inline in mem_arbiter.

Test Plan:
- Single read: m0 reads 0x100; slave returns 0x12345678 one cycle after s_valid. Expect s_addr=0x100, s_wstrb=0, m0_ready in request cycle+2, m0_rdata=0x12345678, m1_ready=0 throughout.
- Tie at reset: m0 and m1 both valid in the same cycle (addr 0x10, 0x20). Expect s_addr=0x10 first, then 0x20; then with both held continuously, grants alternate m0, m1, m0, m1.
- Write strobes: m1 writes wdata=0xAABBCCDD, wstrb=4'b0101 to 0x204. Expect s_wdata/s_wstrb/s_addr identical and stable across 3 slave wait cycles; m1_ready only in the s_ready cycle.
- Timeout: TIMEOUT_CYCLES=4, slave never readies, m0 read. Expect m0_ready with rdata=0xDEADBEEF after 4 BUSY wait cycles; err_timeout pulses next cycle with err_master=0. A later s_ready=1 while s_valid=0 produces no master ready.
- Reset mid-op: assert resetn=0 while BUSY. Expect s_valid=0 immediately (async), no m*_ready; after release, a pending m1 request is granted normally.
- Disabled watchdog: TIMEOUT_CYCLES=0, slave stalls 1000 cycles then readies. Expect no abort, err_timeout stays 0, normal completion.
